// File: rtl/debounce_fsm.sv
// debounce_fsm: two-flop synchronised button debouncer; clk, reset_n (sync, active-low), tick (count enable), btn_in -> debounced level, press_pulse/release_pulse strobes, busy while qualifying
module debounce_fsm #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int COUNT_WIDTH = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic btn_in,
  output logic debounced,
  output logic press_pulse,
  output logic release_pulse,
  output logic busy
);
  typedef enum logic [1:0] {IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW} state_t;
  state_t state, state_nxt;
  logic s1, s2;
  logic [COUNT_WIDTH-1:0] count, count_nxt;
  logic debounced_nxt, press_nxt, release_nxt;
  logic rollover;
  assign rollover = tick && count == COUNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  assign busy = state == WAIT_HIGH || state == WAIT_LOW;
  always_comb begin
    state_nxt = state;
    count_nxt = '0;
    debounced_nxt = debounced;
    press_nxt = 1'b0;
    release_nxt = 1'b0;
    case (state)
      IDLE_LOW: state_nxt = s2 ? WAIT_HIGH : IDLE_LOW;
      IDLE_HIGH: state_nxt = s2 ? IDLE_HIGH : WAIT_LOW;
      WAIT_HIGH:
        if (!s2) state_nxt = IDLE_LOW;
        else if (rollover) begin
          state_nxt = IDLE_HIGH;
          debounced_nxt = 1'b1;
          press_nxt = 1'b1;
        end else count_nxt = count + COUNT_WIDTH'(tick);
      WAIT_LOW:
        if (s2) state_nxt = IDLE_HIGH;
        else if (rollover) begin
          state_nxt = IDLE_LOW;
          debounced_nxt = 1'b0;
          release_nxt = 1'b1;
        end else count_nxt = count + COUNT_WIDTH'(tick);
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      state <= IDLE_LOW;
      count <= '0;
      debounced <= 1'b0;
      press_pulse <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
      state <= state_nxt;
      count <= count_nxt;
      debounced <= debounced_nxt;
      press_pulse <= press_nxt;
      release_pulse <= release_nxt;
    end
  end
endmodule

// File: tb/tb_debounce_fsm.sv
// tb_debounce_fsm: directed stimulus with a per-cycle reference model and literal spot checks
module tb_debounce_fsm;
  localparam int N = 4;
  logic clk = 1'b0;
  logic reset_n, tick, btn_in;
  logic debounced, press_pulse, release_pulse, busy;
  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;
  typedef struct packed {
    logic s1, s2, acc, pend, press, rel;
    int ticks;
  } model_t;
  model_t m;
  debounce_fsm #(.DEBOUNCE_CYCLES(N)) dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .btn_in(btn_in),
    .debounced(debounced), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic model_t step(model_t c, logic rn, logic t, logic b);
    model_t n = c;
    if (!rn) return '0;
    n.press = 1'b0;
    n.rel = 1'b0;
    if (!c.pend) begin
      if (c.s2 != c.acc) begin
        n.pend = 1'b1;
        n.ticks = 0;
      end
    end else if (c.s2 == c.acc) n.pend = 1'b0;
    else if (t) begin
      n.ticks = c.ticks + 1;
      if (n.ticks == N) begin
        n.acc = c.s2;
        n.pend = 1'b0;
        n.press = c.s2;
        n.rel = !c.s2;
      end
    end
    n.s2 = c.s1;
    n.s1 = b;
    return n;
  endfunction
  always @(posedge clk) m <= step(m, reset_n, tick, btn_in);
  task automatic chk(string nm, logic a, logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, a, e);
    end
  endtask
  always @(negedge clk) if (chk_en) begin
    chk("model_debounced", debounced, m.acc);
    chk("model_press", press_pulse, m.press);
    chk("model_release", release_pulse, m.rel);
    chk("model_busy", busy, m.pend);
  end
  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    reset_n = 1'b0;
    tick = 1'b1;
    btn_in = 1'b0;
    cyc(2);
    chk_en = 1'b1;
    chk("reset_debounced", debounced, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_press", press_pulse, 1'b0);
    reset_n = 1'b1;
    cyc(1);
    btn_in = 1'b1;
    cyc(2);
    chk("t1_busy_e2", busy, 1'b0);
    cyc(1);
    chk("t1_busy_e3", busy, 1'b1);
    cyc(3);
    chk("t1_deb_e6", debounced, 1'b0);
    chk("t1_busy_e6", busy, 1'b1);
    cyc(1);
    chk("t1_deb_e7", debounced, 1'b1);
    chk("t1_press_e7", press_pulse, 1'b1);
    chk("t1_busy_e7", busy, 1'b0);
    cyc(1);
    chk("t1_press_e8", press_pulse, 1'b0);
    btn_in = 1'b0;
    cyc(6);
    chk("t5_deb_e6", debounced, 1'b1);
    chk("t5_rel_e6", release_pulse, 1'b0);
    cyc(1);
    chk("t5_rel_e7", release_pulse, 1'b1);
    chk("t5_deb_e7", debounced, 1'b0);
    cyc(1);
    chk("t5_rel_e8", release_pulse, 1'b0);
    btn_in = 1'b1;
    cyc(3);
    btn_in = 1'b0;
    cyc(10);
    chk("t2_deb", debounced, 1'b0);
    chk("t2_busy", busy, 1'b0);
    btn_in = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick = (i % 3 == 0);
      cyc(1);
    end
    chk("t3_deb", debounced, 1'b1);
    tick = 1'b1;
    btn_in = 1'b0;
    cyc(10);
    chk("t3_back_low", debounced, 1'b0);
    tick = 1'b0;
    btn_in = 1'b1;
    cyc(20);
    chk("tick0_busy", busy, 1'b1);
    chk("tick0_deb", debounced, 1'b0);
    btn_in = 1'b0;
    cyc(4);
    chk("tick0_bounce_exit", busy, 1'b0);
    tick = 1'b1;
    btn_in = 1'b1;
    cyc(4);
    btn_in = 1'b0;
    cyc(3);
    chk("t4_press_e7", press_pulse, 1'b0);
    chk("t4_deb_e7", debounced, 1'b0);
    chk("t4_busy_e7", busy, 1'b0);
    cyc(3);
    btn_in = 1'b1;
    cyc(5);
    chk("t6_busy_pre", busy, 1'b1);
    reset_n = 1'b0;
    cyc(1);
    chk("t6_busy_rst", busy, 1'b0);
    chk("t6_deb_rst", debounced, 1'b0);
    reset_n = 1'b1;
    cyc(6);
    chk("t6_deb_e6", debounced, 1'b0);
    cyc(1);
    chk("t6_deb_e7", debounced, 1'b1);
    chk("t6_press_e7", press_pulse, 1'b1);
    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/debounce_fsm.md
Name: debounce_fsm

Overview:
Debounce controller for a single mechanical button input. It synchronizes the raw pin and qualifies level changes with an internal mod-N wait counter. The counter uses increment/clear/rollover semantics. Only transitions that remain stable for DEBOUNCE_CYCLES qualifying ticks are accepted. Sits between the board pin and the button_controller logic, providing a clean level plus one-cycle press/release strobes.

Parameters:
DEBOUNCE_CYCLES, 4, number of qualifying ticks the synchronized input must hold a new level before it is accepted; legal range >= 1.
COUNT_WIDTH, $clog2(DEBOUNCE_CYCLES) (minimum 1), width of the internal wait counter.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset_n  input  1  synchronous, active-low reset.
tick  input  1  count enable for the wait counter, e.g. a prescaler strobe; tie high for per-cycle counting.
btn_in  input  1  raw, asynchronous button level.
debounced  output  1  accepted button level, registered.
press_pulse  output  1  high for exactly one cycle when debounced goes 0->1, registered.
release_pulse  output  1  high for exactly one cycle when debounced goes 1->0, registered.
busy  output  1  high while in WAIT_HIGH or WAIT_LOW, i.e. a candidate transition is being qualified.

Behaviour:
- Reset (reset_n=0 at a rising edge): sync flops=0, state=IDLE_LOW, count=0, debounced=0, press_pulse=0, release_pulse=0. Reset dominates all other inputs. A reset mid-wait abandons the qualification.
- Synchronizer: two-flop chain btn_in->s1->s2. The FSM only observes s2, giving 2 cycles of input latency.
- Wait counter:
  - Cleared on every entry to a WAIT state.
  - In WAIT states, increments by 1 when tick=1.
  - Holds when tick=0.
  - rollover = (tick && count==DEBOUNCE_CYCLES-1), combinational and internal.
  - Count never exceeds DEBOUNCE_CYCLES-1.
  - Outside WAIT states, count is held at 0.
- States:
  - IDLE_LOW: s2=1 -> WAIT_HIGH (count<=0); else stay.
  - WAIT_HIGH:
    - s2=0 -> IDLE_LOW (bounce rejected, count<=0).
    - Else if rollover -> IDLE_HIGH, debounced<=1, press_pulse<=1.
    - Else stay.
  - IDLE_HIGH: s2=0 -> WAIT_LOW (count<=0); else stay.
  - WAIT_LOW: mirror of WAIT_HIGH. s2=1 -> IDLE_HIGH (rejected). Rollover -> IDLE_LOW, debounced<=0, release_pulse<=1.
- Simultaneous events: if s2 reverts in the same cycle as rollover, the bounce wins. The state returns to IDLE, debounced is unchanged and no pulse is emitted.
- Pulses are cleared on the following edge, so each is 1 cycle wide. press_pulse and release_pulse are never both high.
- Latency with tick held at 1: number the first rising edge that samples btn_in=1 as edge 1. Edge 3 enters WAIT_HIGH. debounced and press_pulse go high after edge DEBOUNCE_CYCLES+3.
- DEBOUNCE_CYCLES=1: rollover occurs on the first tick after entering WAIT.
- With tick=0 forever, a WAIT state persists indefinitely; busy stays 1 and only a bounce can exit.
- busy=0 in reset and in both IDLE states.

Test Plan:
1. N=4, tick=1: btn_in 0->1 and held -> debounced=1 and press_pulse=1 for one cycle after edge 7. busy is high from after edge 3 until after edge 7.
2. N=4, tick=1: btn_in high for 3 cycles, then low -> no press_pulse, debounced stays 0, FSM returns to IDLE_LOW.
3. N=4, tick asserted every 3rd cycle, btn_in held high -> debounced rises on the 4th tick after WAIT entry. Count holds between ticks.
4. Simultaneous event: s2 drops in the same cycle count==3 with tick=1 -> no press_pulse, debounced=0.
5. From debounced=1, btn_in 1->0 held, N=4 -> release_pulse for one cycle after edge 7; debounced=0.
6. reset_n=0 for one cycle while in WAIT_HIGH with count=2 -> next cycle state=IDLE_LOW, count=0, all outputs 0. Requalification restarts from scratch.
